mem_arbiter: RTL and testbench

//  Shares the single data RAM port between instruction fetch (m0, read-only) and load/store (m1).

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter_starve_cnt.sv | 28 ++
 rtl/mem_arbiter.sv | 85 ++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and default widths for the data-RAM arbiter.
// The starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
package mem_arb_pkg;

    localparam int DEF_AW         = 32;
    localparam int DEF_DW         = 32;
    localparam int WE_W           = 4;
    localparam int DEF_STARVE_MAX = 4;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h1000;

    // Tag carried with a read so the response returns to the right master
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between fetch (m0), load/store (m1), the arbiter and the RAM port.
// slave = arbiter side, master = requesters plus RAM.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic            m0_req;
    logic [AW-1:0]   m0_addr;
    logic            m0_gnt;
    logic            m0_rvalid;
    logic [DW-1:0]   m0_rdata;

    logic            m1_req;
    logic [WE_W-1:0] m1_we;
    logic [AW-1:0]   m1_addr;
    logic [DW-1:0]   m1_wdata;
    logic            m1_gnt;
    logic            m1_rvalid;
    logic [DW-1:0]   m1_rdata;

    logic            s_ren;
    logic [AW-1:0]   s_raddr;
    logic [WE_W-1:0] s_wen;
    logic [AW-1:0]   s_waddr;
    logic [DW-1:0]   s_wdata;
    logic [DW-1:0]   s_rdata;

    modport slave (
        input  m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, s_rdata,
        output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
        output s_ren, s_raddr, s_wen, s_waddr, s_wdata
    );

    modport master (
        output m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, s_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
        input  s_ren, s_raddr, s_wen, s_waddr, s_wdata
    );
endinterface

// File: rtl/mem_arbiter_starve_cnt.sv
// Saturating count of consecutive fetch denials; hit tells the arbiter to let fetch through.
// Only instantiated when ARB_STARVE_GUARD_EN is defined.
module arb_starve_cnt #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic inc,
    input  logic clr,
    output logic hit
);
    localparam int CW = $clog2(MAX + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != CW'(MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = (cnt == CW'(MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Single data-RAM port shared by fetch (m0) and load/store (m1); one access per cycle.
// Define ARB_STARVE_GUARD_EN to bound how long fetch can be starved by load/store.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int            AW         = DEF_AW,
    parameter int            DW         = DEF_DW,
    parameter logic [AW-1:0] BASE_ADDR  = AW'(DEF_BASE_ADDR),
    parameter int            STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic rstn,
    input  logic flush_i,
    output logic stall_o,
    mem_arbiter_if.slave bus
);
    logic   m0_live, m1_live;
    logic   m0_gnt, m1_gnt;
    logic   m1_rd, rd_gnt;
    logic   starve_hit;
    logic   resp_vld_q;
    owner_e resp_own_q;

`ifdef ARB_STARVE_GUARD_EN
    arb_starve_cnt #(.MAX(STARVE_MAX)) u_starve (
        .clk  (clk),
        .rstn (rstn),
        .inc  (bus.m0_req & ~m0_gnt & ~flush_i),
        .clr  (m0_gnt | flush_i),
        .hit  (starve_hit)
    );
`else
    assign starve_hit = 1'b0;
`endif

    // Grants are held low throughout reset, not just after the first edge
    assign m0_live = rstn & bus.m0_req & ~flush_i;
    assign m1_live = rstn & bus.m1_req;
    assign m1_gnt  = m1_live & ~(starve_hit & m0_live);
    assign m0_gnt  = m0_live & ~m1_gnt;
    assign m1_rd   = m1_gnt & (bus.m1_we == '0);
    assign rd_gnt  = m0_gnt | m1_rd;

    assign bus.m0_gnt = m0_gnt;
    assign bus.m1_gnt = m1_gnt;
    assign stall_o    = bus.m0_req & ~m0_gnt;

    always_comb begin
        bus.s_ren   = 1'b0;
        bus.s_raddr = '0;
        bus.s_wen   = '0;
        bus.s_waddr = '0;
        bus.s_wdata = '0;
        if (m1_gnt) begin
            if (bus.m1_we != '0) begin
                bus.s_wen   = bus.m1_we;
                bus.s_waddr = bus.m1_addr - BASE_ADDR;
                bus.s_wdata = bus.m1_wdata;
            end else begin
                bus.s_ren   = 1'b1;
                bus.s_raddr = bus.m1_addr - BASE_ADDR;
            end
        end else if (m0_gnt) begin
            bus.s_ren   = 1'b1;
            bus.s_raddr = bus.m0_addr - BASE_ADDR;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_vld_q <= 1'b0;
            resp_own_q <= OWN_IF;
        end else begin
            resp_vld_q <= rd_gnt;
            if (rd_gnt) resp_own_q <= m1_rd ? OWN_LS : OWN_IF;
        end
    end

    // A flush kills the fetch response in the cycle it would have been consumed
    assign bus.m0_rvalid = resp_vld_q & (resp_own_q == OWN_IF) & ~flush_i;
    assign bus.m1_rvalid = resp_vld_q & (resp_own_q == OWN_LS);
    assign bus.m0_rdata  = bus.s_rdata;
    assign bus.m1_rdata  = bus.s_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic vs a reference model.
// Expected starvation behaviour follows ARB_STARVE_GUARD_EN.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam int          SMAX = 4;
    localparam logic [31:0] BASE = 32'h1000;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic flush = 1'b0;
    logic stall;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus();

    mem_arbiter #(.AW(AW), .DW(DW), .BASE_ADDR(BASE), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rstn(rstn), .flush_i(flush), .stall_o(stall), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    int n = 0;
    int p = 0;

    // reference model state
    bit          pend, pown;
    logic [31:0] pend_data;
    int          denials;
    // expectations for the current cycle
    bit          e_g0, e_g1, e_stall, e_ren, e_rv0, e_rv1;
    logic [3:0]  e_wen;
    logic [31:0] e_raddr, e_waddr, e_wdata, e_rdata;

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    // RAM behind the slave port: read data one cycle after s_ren
    always @(posedge clk) begin
        if (bus.s_ren) bus.s_rdata <= mem[bus.s_raddr[7:2]];
        for (int b = 0; b < 4; b++)
            if (bus.s_wen[b]) mem[bus.s_waddr[7:2]][8*b +: 8] <= bus.s_wdata[8*b +: 8];
    end

    task automatic idle_inputs();
        bus.m0_req = 1'b0; bus.m0_addr = '0;
        bus.m1_req = 1'b0; bus.m1_we = '0; bus.m1_addr = '0; bus.m1_wdata = '0;
        flush = 1'b0;
    endtask

    // Apply one cycle of stimulus at the falling edge and compute what the DUT should show
    task automatic drive(input logic m0r, input logic [31:0] m0a, input logic m1r,
                         input logic [3:0] we, input logic [31:0] m1a, input logic [31:0] wd,
                         input logic fl);
        bit force0, rd;
        logic [31:0] off;
        @(negedge clk);
        bus.m0_req = m0r; bus.m0_addr = m0a;
        bus.m1_req = m1r; bus.m1_we = we; bus.m1_addr = m1a; bus.m1_wdata = wd;
        flush = fl;

        e_rv0   = rstn && pend && !pown && !fl;
        e_rv1   = rstn && pend && pown;
        e_rdata = pend_data;
        force0  = GUARD && denials >= SMAX && m0r && !fl;
        e_g1    = rstn && m1r && !force0;
        e_g0    = rstn && m0r && !fl && !e_g1;
        e_stall = m0r && !e_g0;
        e_ren = 0; e_wen = '0; e_raddr = '0; e_waddr = '0; e_wdata = '0;
        rd = 0;
        if (e_g1 && we != 4'b0) begin
            e_wen = we; e_waddr = m1a - BASE; e_wdata = wd;
        end else if (e_g1 || e_g0) begin
            e_ren = 1; e_raddr = (e_g1 ? m1a : m0a) - BASE; rd = 1;
        end

        pend = rd;
        pown = e_g1;
        if (rd) pend_data = ref_mem[e_raddr[7:2]];
        off = e_waddr;
        for (int b = 0; b < 4; b++)
            if (e_wen[b]) ref_mem[off[7:2]][8*b +: 8] = wd[8*b +: 8];
        if (!rstn || fl || e_g0) denials = 0;
        else if (m0r && denials < SMAX) denials++;
        #1;
    endtask

    task automatic test_reset();
        drive(1, BASE, 1, 4'b0000, BASE + 4, 0, 0);
        n++; if (bus.m0_gnt !== 1'b0) $display("FAIL rst_m0_gnt act=%b exp=0", bus.m0_gnt); else p++;
        n++; if (bus.m1_gnt !== 1'b0) $display("FAIL rst_m1_gnt act=%b exp=0", bus.m1_gnt); else p++;
        n++; if ({bus.s_ren, bus.s_wen} !== 5'b0) $display("FAIL rst_s_en act=%b exp=0", {bus.s_ren, bus.s_wen}); else p++;
        n++; if ({bus.m0_rvalid, bus.m1_rvalid} !== 2'b00) $display("FAIL rst_rvalid act=%b exp=00", {bus.m0_rvalid, bus.m1_rvalid}); else p++;
        idle_inputs();
        rstn = 1'b1;
    endtask

    task automatic test_fetch();
        drive(1, 32'h1008, 0, 0, 0, 0, 0);
        n++; if (bus.m0_gnt !== 1'b1) $display("FAIL fetch_gnt act=%b exp=1", bus.m0_gnt); else p++;
        n++; if (bus.s_ren !== 1'b1 || bus.s_raddr !== 32'h8) $display("FAIL fetch_raddr act=%b/%h exp=1/8", bus.s_ren, bus.s_raddr); else p++;
        n++; if (stall !== 1'b0) $display("FAIL fetch_stall act=%b exp=0", stall); else p++;
        drive(1, 32'h0FFC, 0, 0, 0, 0, 0);
        n++; if (bus.m0_rvalid !== 1'b1 || bus.m1_rvalid !== 1'b0) $display("FAIL fetch_rvalid act=%b%b exp=10", bus.m0_rvalid, bus.m1_rvalid); else p++;
        n++; if (bus.m0_rdata !== init_word(2)) $display("FAIL fetch_rdata act=%h exp=%h", bus.m0_rdata, init_word(2)); else p++;
        n++; if (bus.s_raddr !== 32'hFFFF_FFFC) $display("FAIL fetch_wrap act=%h exp=fffffffc", bus.s_raddr); else p++;
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_contention();
        drive(1, 32'h1020, 1, 0, 32'h1010, 0, 0);
        n++; if ({bus.m1_gnt, bus.m0_gnt, stall} !== 3'b101) $display("FAIL cont_gnt act=%b exp=101", {bus.m1_gnt, bus.m0_gnt, stall}); else p++;
        n++; if (bus.s_raddr !== 32'h10) $display("FAIL cont_raddr act=%h exp=10", bus.s_raddr); else p++;
        drive(0, 0, 0, 0, 0, 0, 0);
        n++; if ({bus.m1_rvalid, bus.m0_rvalid} !== 2'b10) $display("FAIL cont_rvalid act=%b exp=10", {bus.m1_rvalid, bus.m0_rvalid}); else p++;
        n++; if (bus.m1_rdata !== init_word(4)) $display("FAIL cont_rdata act=%h exp=%h", bus.m1_rdata, init_word(4)); else p++;
    endtask

    task automatic test_store();
        logic [31:0] w, exp;
        drive(0, 0, 1, 4'b0011, 32'h1004, 32'hDEADBEEF, 0);
        n++; if (bus.s_wen !== 4'b0011 || bus.s_waddr !== 32'h4) $display("FAIL st_wen act=%b/%h exp=0011/4", bus.s_wen, bus.s_waddr); else p++;
        n++; if (bus.s_wdata !== 32'hDEADBEEF || bus.s_ren !== 1'b0) $display("FAIL st_wdata act=%h/%b exp=deadbeef/0", bus.s_wdata, bus.s_ren); else p++;
        drive(0, 0, 1, 4'b0000, 32'h1004, 0, 0);
        n++; if ({bus.m0_rvalid, bus.m1_rvalid} !== 2'b00) $display("FAIL st_no_rvalid act=%b exp=00", {bus.m0_rvalid, bus.m1_rvalid}); else p++;
        drive(0, 0, 0, 0, 0, 0, 0);
        w = init_word(1);
        exp = {w[31:16], 16'hBEEF};
        n++; if (bus.m1_rvalid !== 1'b1 || bus.m1_rdata !== exp) $display("FAIL st_readback act=%b/%h exp=1/%h", bus.m1_rvalid, bus.m1_rdata, exp); else p++;
    endtask

    task automatic test_flush();
        drive(1, 32'h100C, 0, 0, 0, 0, 0);
        n++; if (bus.m0_gnt !== 1'b1) $display("FAIL fl_gnt0 act=%b exp=1", bus.m0_gnt); else p++;
        drive(1, 32'h1010, 0, 0, 0, 0, 1);
        n++; if (bus.m0_rvalid !== 1'b0) $display("FAIL fl_rvalid act=%b exp=0", bus.m0_rvalid); else p++;
        n++; if ({bus.m0_gnt, stall, bus.s_ren} !== 3'b010) $display("FAIL fl_gnt act=%b exp=010", {bus.m0_gnt, stall, bus.s_ren}); else p++;
        drive(0, 0, 1, 0, 32'h1018, 0, 0);
        n++; if (bus.m1_gnt !== 1'b1) $display("FAIL fl_m1_gnt act=%b exp=1", bus.m1_gnt); else p++;
        drive(0, 0, 0, 0, 0, 0, 1);
        n++; if (bus.m1_rvalid !== 1'b1 || bus.m1_rdata !== init_word(6)) $display("FAIL fl_m1_keep act=%b/%h exp=1/%h", bus.m1_rvalid, bus.m1_rdata, init_word(6)); else p++;
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_starve();
        bit exp0;
        int g0 = 0;
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 15; i++) begin
            drive(1, BASE + 32'(4 * i), 1, 0, BASE + 32'h20, 0, 0);
            exp0 = GUARD && (i % 5 == 4);
            if (bus.m0_gnt === 1'b1) g0++;
            n++; if ({bus.m0_gnt, bus.m1_gnt} !== {exp0, !exp0}) $display("FAIL starve_c%0d act=%b%b exp=%b%b", i, bus.m0_gnt, bus.m1_gnt, exp0, !exp0); else p++;
        end
        n++; if (g0 !== (GUARD ? 3 : 0)) $display("FAIL starve_total act=%0d exp=%0d", g0, GUARD ? 3 : 0); else p++;
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [31:0] a0, a1;
        logic [3:0]  we;
        for (int c = 0; c < 400; c++) begin
            a0 = BASE + 32'(4 * $urandom_range(0, 63));
            if ($urandom_range(0, 15) == 0) a0 = BASE - 32'(4 * $urandom_range(1, 8));
            a1 = BASE + 32'(4 * $urandom_range(0, 63));
            we = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
            drive(1'($urandom_range(0, 1)), a0, 1'($urandom_range(0, 1)), we, a1, $urandom,
                  1'($urandom_range(0, 7) == 0));
            n++; if ({bus.m0_gnt, bus.m1_gnt, stall, bus.s_ren, bus.s_wen} !== {e_g0, e_g1, e_stall, e_ren, e_wen})
                $display("FAIL rnd_ctl c%0d act=%b exp=%b", c, {bus.m0_gnt, bus.m1_gnt, stall, bus.s_ren, bus.s_wen}, {e_g0, e_g1, e_stall, e_ren, e_wen});
            else p++;
            n++; if ({bus.s_raddr, bus.s_waddr, bus.s_wdata} !== {e_raddr, e_waddr, e_wdata})
                $display("FAIL rnd_bus c%0d act=%h/%h/%h exp=%h/%h/%h", c, bus.s_raddr, bus.s_waddr, bus.s_wdata, e_raddr, e_waddr, e_wdata);
            else p++;
            n++; if ({bus.m0_rvalid, bus.m1_rvalid} !== {e_rv0, e_rv1})
                $display("FAIL rnd_rvalid c%0d act=%b%b exp=%b%b", c, bus.m0_rvalid, bus.m1_rvalid, e_rv0, e_rv1);
            else p++;
            if (e_rv0 || e_rv1) begin
                n++; if (bus.m0_rdata !== e_rdata || bus.m1_rdata !== e_rdata)
                    $display("FAIL rnd_rdata c%0d act=%h/%h exp=%h", c, bus.m0_rdata, bus.m1_rdata, e_rdata);
                else p++;
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        drive(1, 32'h1014, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        n++; if (bus.m0_rvalid !== 1'b1) $display("FAIL rmid_pending act=%b exp=1", bus.m0_rvalid); else p++;
        rstn = 1'b0;
        pend = 0; denials = 0;
        #1;
        n++; if ({bus.m0_rvalid, bus.m1_rvalid} !== 2'b00) $display("FAIL rmid_drop act=%b exp=00", {bus.m0_rvalid, bus.m1_rvalid}); else p++;
        n++; if ({bus.m0_gnt, bus.s_ren} !== 2'b00) $display("FAIL rmid_gnt act=%b exp=00", {bus.m0_gnt, bus.s_ren}); else p++;
        @(negedge clk);
        idle_inputs();
        rstn = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        n++; if ({bus.m0_rvalid, bus.m1_rvalid} !== 2'b00) $display("FAIL rmid_after act=%b exp=00", {bus.m0_rvalid, bus.m1_rvalid}); else p++;
        drive(1, 32'h1014, 0, 0, 0, 0, 0);
        exp = ref_mem[5];
        drive(0, 0, 0, 0, 0, 0, 0);
        n++; if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== exp) $display("FAIL rmid_new act=%b/%h exp=1/%h", bus.m0_rvalid, bus.m0_rdata, exp); else p++;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        idle_inputs();
        bus.s_rdata = '0;
        pend = 0; pown = 0; pend_data = '0; denials = 0;
        test_reset();
        test_fetch();
        test_contention();
        test_store();
        test_flush();
        test_starve();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", p, n);
        $finish;
    end

endmodule
